// File: rtl/dmem_responder.sv
// dmem_responder: request/response slave in front of a word-addressed RAM.
// It accepts one load or store at a time and inserts LATENCY wait states.
// It then returns a single-cycle response strobe.
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned accesses.
// A flagged access gets resp_err=1, its store is suppressed and its load data is zeroed.
module dmem_responder #(
   parameter int DEPTH_LOG2 = 13,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int         DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [3:0] LAT_INIT = 4'(LATENCY);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                state_r;
   state_t                state_nxt_s;
   logic [3:0]            cnt_r;
   logic                  cap_write_r;
   logic [31:0]           cap_addr_r;
   logic [31:0]           cap_wdata_r;
   logic [31:0]           mem_r [0:DEPTH-1];

   logic                  accept_s;
   logic                  enter_resp_s;
   logic                  op_write_s;
   logic [31:0]           op_addr_s;
   logic [31:0]           op_wdata_s;
   logic                  misalign_s;
   logic [DEPTH_LOG2-1:0] widx_s;
   logic                  unused_s;

   assign accept_s = req_valid & req_ready;

   // Next-state logic; also marks the edge on which the access is performed
   always_comb begin
      state_nxt_s  = state_r;
      enter_resp_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (LAT_INIT == 4'd0) begin
                  state_nxt_s  = ST_RESP;
                  enter_resp_s = 1'b1;
               end else begin
                  state_nxt_s  = ST_WAIT;
                  enter_resp_s = 1'b0;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_r <= 4'd1) begin
               state_nxt_s  = ST_RESP;
               enter_resp_s = 1'b1;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_RESP: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Operand source: with zero latency the access happens on the accept edge itself,
   // before the capture registers are loaded, so use the live request then
   always_comb begin
      op_write_s = cap_write_r;
      op_addr_s  = cap_addr_r;
      op_wdata_s = cap_wdata_r;
      if (state_r == ST_IDLE) begin
         op_write_s = req_write;
         op_addr_s  = req_addr;
         op_wdata_s = req_wdata;
      end else begin
         op_write_s = cap_write_r;
         op_addr_s  = cap_addr_r;
         op_wdata_s = cap_wdata_r;
      end
   end

`ifdef DMEM_ALIGN_CHECK_EN
   assign misalign_s = (op_addr_s[1:0] != 2'b00);
`else
   assign misalign_s = 1'b0;
`endif

   // Word index ignores the byte offset and the address bits above the RAM size
   assign widx_s   = op_addr_s[DEPTH_LOG2+1:2];
   assign unused_s = ^{op_addr_s[31:DEPTH_LOG2+2], op_addr_s[1:0]};

   // State, counter, capture registers and registered handshake/response outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 4'd0;
         req_ready   <= 1'b0;
         resp_valid  <= 1'b0;
         resp_rdata  <= 32'd0;
         resp_err    <= 1'b0;
         cap_write_r <= 1'b0;
         cap_addr_r  <= 32'd0;
         cap_wdata_r <= 32'd0;
      end else begin
         state_r    <= state_nxt_s;
         req_ready  <= (state_nxt_s == ST_IDLE);
         resp_valid <= (state_nxt_s == ST_RESP);
         if (accept_s) begin
            cap_write_r <= req_write;
            cap_addr_r  <= req_addr;
            cap_wdata_r <= req_wdata;
            cnt_r       <= LAT_INIT;
         end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r - 4'd1;
         end else begin
            cnt_r <= cnt_r;
         end
         if (enter_resp_s) begin
            resp_err <= misalign_s;
            if (op_write_s || misalign_s) begin
               resp_rdata <= 32'd0;
            end else begin
               resp_rdata <= mem_r[widx_s];
            end
         end
      end
   end

   // RAM write port: contents are not reset; an aborted store never reaches this edge
   always_ff @(posedge clk) begin
      if (enter_resp_s && op_write_s && !misalign_s) begin
         mem_r[widx_s] <= op_wdata_s;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with LATENCY=2 follows a transaction-level model.
// A second instance with LATENCY=0 is checked against literal expectations.
module tb_dmem_responder;
   localparam int LAT_A = 2;
   localparam int DL2   = 13;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        use0;
   logic        bus_valid, bus_write;
   logic [31:0] bus_addr, bus_wdata;

   logic        a_valid, a_ready, a_write, a_resp, a_err;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic        b_valid, b_ready, b_write, b_resp, b_err;
   logic [31:0] b_addr, b_wdata, b_rdata;
   logic        s_ready, s_resp, s_err;
   logic [31:0] s_rdata;

   assign a_valid = bus_valid & ~use0;
   assign a_write = bus_write;
   assign a_addr  = bus_addr;
   assign a_wdata = bus_wdata;
   assign b_valid = bus_valid & use0;
   assign b_write = bus_write;
   assign b_addr  = bus_addr;
   assign b_wdata = bus_wdata;
   assign s_ready = use0 ? b_ready : a_ready;
   assign s_resp  = use0 ? b_resp  : a_resp;
   assign s_err   = use0 ? b_err   : a_err;
   assign s_rdata = use0 ? b_rdata : a_rdata;

   dmem_responder #(.DEPTH_LOG2(DL2), .LATENCY(LAT_A)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
      .req_write(a_write), .req_addr(a_addr), .req_wdata(a_wdata),
      .resp_valid(a_resp), .resp_rdata(a_rdata), .resp_err(a_err));

   dmem_responder #(.DEPTH_LOG2(DL2), .LATENCY(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
      .req_write(b_write), .req_addr(b_addr), .req_wdata(b_wdata),
      .resp_valid(b_resp), .resp_rdata(b_rdata), .resp_err(b_err));

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model of the LATENCY=2 instance ----------------
   logic [31:0] mem [int];
   logic        m_ready, m_valid, m_err, m_known, was_valid, busy, p_write, mis;
   logic [31:0] m_rdata, p_addr, p_wdata;
   int          cyc, due, widx;

   initial begin
      m_ready = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_known = 1'b0; m_rdata = 32'd0;
      busy = 1'b0; cyc = 0; due = 0; p_write = 1'b0; p_addr = 32'd0; p_wdata = 32'd0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            busy = 1'b0; m_ready = 1'b0; m_valid = 1'b0; m_rdata = 32'd0; m_err = 1'b0;
         end else begin
            cyc++;
            was_valid = m_valid;
            m_valid   = 1'b0;
            if (m_ready && a_valid) begin
               busy = 1'b1; due = cyc + LAT_A; m_ready = 1'b0;
               p_write = a_write; p_addr = a_addr; p_wdata = a_wdata;
            end else if (!busy) begin
               m_ready = 1'b1;
            end
            if (busy && cyc == due) begin
               widx = int'(p_addr[DL2+1:2]);
               mis  = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
               mis  = (p_addr[1:0] != 2'b00);
`endif
               m_err = mis; m_valid = 1'b1; m_known = 1'b1;
               if (p_write) begin
                  m_rdata = 32'd0;
                  if (!mis) mem[widx] = p_wdata;
               end else if (mis) begin
                  m_rdata = 32'd0;
               end else if (mem.exists(widx)) begin
                  m_rdata = mem[widx];
               end else begin
                  m_known = 1'b0;
               end
            end
            if (was_valid) begin
               busy = 1'b0; m_ready = 1'b1;
            end
         end
      end
   end

   // Every-cycle comparison of the LATENCY=2 instance against the model
   initial begin
      forever begin
         @(negedge clk);
         check("m_ready", {31'd0, a_ready}, {31'd0, m_ready});
         check("m_resp_valid", {31'd0, a_resp}, {31'd0, m_valid});
         if (m_valid) begin
            check("m_resp_err", {31'd0, a_err}, {31'd0, m_err});
            if (m_known) check("m_resp_rdata", a_rdata, m_rdata);
         end
      end
   end

   // One request on the selected instance, with latency/data/err checked against literals
   task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input string tag,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
      int n;
      n = 0;
      while (!s_ready && n < 50) begin @(negedge clk); n++; end
      check({tag, "_ready"}, {31'd0, s_ready}, 32'd1);
      bus_valid = 1'b1; bus_write = w; bus_addr = a; bus_wdata = d;
      @(negedge clk);
      bus_valid = 1'b0;
      n = 0;
      while (!s_resp && n < 50) begin @(negedge clk); n++; end
      check({tag, "_lat"}, 32'(n), 32'(exp_lat));
      check({tag, "_rdata"}, s_rdata, exp_rd);
      check({tag, "_err"}, {31'd0, s_err}, {31'd0, exp_err});
      @(negedge clk);
   endtask

   // Continuous req_valid with alternating store/load; checks accept spacing
   task automatic stream(input string tag, input int spacing, input int exp_acc);
      int  prev, nacc;
      logic r;
      prev = -1; nacc = 0;
      bus_valid = 1'b1; bus_write = 1'b1; bus_addr = 32'h0000_0040; bus_wdata = 32'h0BAD_F00D;
      for (int i = 0; i < 20; i++) begin
         r = s_ready;
         @(negedge clk);
         if (r) begin
            if (prev >= 0) check({tag, "_spacing"}, 32'(i - prev), 32'(spacing));
            prev = i; nacc++;
            if (bus_write) begin
               bus_write = 1'b0;
            end else begin
               bus_write = 1'b1; bus_addr = bus_addr + 32'd4; bus_wdata = bus_wdata + 32'h1111_1111;
            end
         end
      end
      bus_valid = 1'b0;
      check({tag, "_accepts"}, 32'(nacc), 32'(exp_acc));
      repeat (6) @(negedge clk);
   endtask

   logic        exp_mis_err;
   logic [31:0] exp_mis_rd;

   initial begin
`ifdef DMEM_ALIGN_CHECK_EN
      exp_mis_err = 1'b1; exp_mis_rd = 32'h0102_0304;
`else
      exp_mis_err = 1'b0; exp_mis_rd = 32'hAAAA_5555;
`endif
      rst_n = 1'b0; use0 = 1'b0;
      bus_valid = 1'b0; bus_write = 1'b0; bus_addr = 32'd0; bus_wdata = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, a_ready}, 32'd0);
      check("rst_rdata", a_rdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_release", {31'd0, a_ready}, 32'd1);

      // store/load round trip, three edges from accept to response
      txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "st10", 32'd0, 1'b0, 2);
      txn(1'b0, 32'h0000_0010, 32'd0, "ld10", 32'hDEAD_BEEF, 1'b0, 2);
      // wrap-around of the word index
      txn(1'b1, 32'h0000_8004, 32'h1234_5678, "st8004", 32'd0, 1'b0, 2);
      txn(1'b0, 32'h0000_0004, 32'd0, "ld0004", 32'h1234_5678, 1'b0, 2);
      // misaligned store
      txn(1'b1, 32'h0000_0010, 32'h0102_0304, "st10b", 32'd0, 1'b0, 2);
      txn(1'b1, 32'h0000_0012, 32'hAAAA_5555, "st12", 32'd0, exp_mis_err, 2);
      txn(1'b0, 32'h0000_0010, 32'd0, "ld10b", exp_mis_rd, 1'b0, 2);
      // back-to-back handshakes
      stream("a", LAT_A + 2, 5);

      // reset during WAIT of a store
      txn(1'b1, 32'h0000_0020, 32'h1111_1111, "st20", 32'd0, 1'b0, 2);
      txn(1'b0, 32'h0000_0020, 32'd0, "ld20", 32'h1111_1111, 1'b0, 2);
      bus_valid = 1'b1; bus_write = 1'b1; bus_addr = 32'h0000_0020; bus_wdata = 32'h9999_9999;
      @(negedge clk);
      bus_valid = 1'b0;
      check("abort_in_wait", {31'd0, a_ready}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("abort_ready", {31'd0, a_ready}, 32'd0);
      check("abort_valid", {31'd0, a_resp}, 32'd0);
      check("abort_rdata", a_rdata, 32'd0);
      check("abort_err", {31'd0, a_err}, 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("abort_ready_release", {31'd0, a_ready}, 32'd1);
      txn(1'b0, 32'h0000_0020, 32'd0, "ld20_after_abort", 32'h1111_1111, 1'b0, 2);

      // zero-latency instance
      use0 = 1'b1;
      txn(1'b1, 32'h0000_0100, 32'hCAFE_F00D, "l0_st", 32'd0, 1'b0, 0);
      txn(1'b0, 32'h0000_0100, 32'd0, "l0_ld", 32'hCAFE_F00D, 1'b0, 0);
      stream("l0", 2, 10);
      use0 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
